// File: rtl/seq_detector_prog.sv
// -----------------------------------------------------------------------------
// seq_detector_prog
//   Runtime-programmable Moore serial sequence detector. A pattern of up to
//   PAT_W bits and its length are loaded at run time. detect is held high for
//   HOLD cycles after each match, and a match inside the hold window restarts
//   the window. With OVERLAP=0 the bits of a completed match are not reused.
//
// Optional feature macro: SEQ_DET_COUNT_EN
//   defined   : saturating match counter built, driven on match_count
//   undefined : no counter logic, match_count tied to 0
//
// Ports
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   en           in   seq_in valid this cycle
//   seq_in       in   serial data bit
//   cfg_load     in   load cfg_pattern/cfg_len and clear runtime state
//   cfg_pattern  in   pattern, LSB-aligned, bit [len-1] received first
//   cfg_len      in   pattern length (0 disables detection)
//   detect       out  registered detect flag
//   match_count  out  saturating match count (0 when counter not built)
// -----------------------------------------------------------------------------
module seq_detector_prog #(
  parameter int unsigned       PAT_W       = 8,
  parameter int unsigned       LEN_W       = $clog2(PAT_W + 1),
  parameter logic [PAT_W-1:0]  DEF_PATTERN = 'b0000_0101,
  parameter int unsigned       DEF_LEN     = 4,
  parameter int unsigned       HOLD        = 2,
  parameter int unsigned       OVERLAP     = 1,
  parameter int unsigned       CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             seq_in,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  output logic             detect,
  output logic [CNT_W-1:0] match_count
);

  localparam int unsigned HOLD_W = $clog2(HOLD + 1);
  localparam int unsigned FILL_W = $clog2(PAT_W + 1);

  logic [PAT_W-1:0]  r_hist;
  logic [FILL_W-1:0] r_fill;
  logic              r_fresh;
  logic [HOLD_W-1:0] r_hold;
  logic [PAT_W-1:0]  r_pat;
  logic [LEN_W-1:0]  r_len;
  logic              r_detect;

  logic [PAT_W-1:0]  w_hist_nxt;
  logic [FILL_W-1:0] w_fill_nxt;
  logic              w_fresh_nxt;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic [PAT_W-1:0]  w_pat_nxt;
  logic [LEN_W-1:0]  w_len_nxt;
  logic              w_detect_nxt;

  logic              w_accept;
  logic              w_match;
  int unsigned       w_len_eff;
  logic [PAT_W-1:0]  w_mask;

  assign w_accept = en & ~cfg_load;

  // Effective length clamps len to PAT_W; mask selects the compared history bits
  always_comb begin
    w_len_eff = (32'(r_len) > PAT_W) ? PAT_W : 32'(r_len);
    w_mask    = '0;
    for (int unsigned i = 0; i < PAT_W; i++) begin
      w_mask[i] = (i < w_len_eff);
    end
  end

  // Only a freshly accepted bit can complete a match, so gaps never re-fire
  assign w_match = r_fresh && (w_len_eff != 0) && (32'(r_fill) >= w_len_eff) &&
                   (((r_hist ^ r_pat) & w_mask) == '0);

  // Next-state logic
  always_comb begin
    w_hist_nxt  = r_hist;
    w_fill_nxt  = r_fill;
    w_fresh_nxt = 1'b0;
    w_hold_nxt  = r_hold;
    w_pat_nxt   = r_pat;
    w_len_nxt   = r_len;

    if (cfg_load) begin
      w_pat_nxt  = cfg_pattern;
      w_len_nxt  = cfg_len;
      w_hist_nxt = '0;
      w_fill_nxt = '0;
      w_hold_nxt = '0;
    end else begin
      if (w_accept) begin
        w_hist_nxt  = {r_hist[PAT_W-2:0], seq_in};
        w_fresh_nxt = 1'b1;
        if (32'(r_fill) < PAT_W) begin
          w_fill_nxt = r_fill + FILL_W'(1);
        end
      end

      if (w_match) begin
        w_hold_nxt = HOLD_W'(HOLD);
        // Non-overlapping: only a bit arriving in this same cycle survives
        if (OVERLAP == 0) begin
          w_fill_nxt = w_accept ? FILL_W'(1) : FILL_W'(0);
        end
      end else if (r_hold != '0) begin
        w_hold_nxt = r_hold - HOLD_W'(1);
      end
    end

    w_detect_nxt = (w_hold_nxt != '0);
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist   <= '0;
      r_fill   <= '0;
      r_fresh  <= 1'b0;
      r_hold   <= '0;
      r_pat    <= DEF_PATTERN;
      r_len    <= LEN_W'(DEF_LEN);
      r_detect <= 1'b0;
    end else begin
      r_hist   <= w_hist_nxt;
      r_fill   <= w_fill_nxt;
      r_fresh  <= w_fresh_nxt;
      r_hold   <= w_hold_nxt;
      r_pat    <= w_pat_nxt;
      r_len    <= w_len_nxt;
      r_detect <= w_detect_nxt;
    end
  end

  assign detect = r_detect;

`ifdef SEQ_DET_COUNT_EN
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;

  // Saturating match counter, cleared by cfg_load
  always_comb begin
    w_count_nxt = r_count;
    if (cfg_load) begin
      w_count_nxt = '0;
    end else if (w_match && (r_count != '1)) begin
      w_count_nxt = r_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
    end
  end

  assign match_count = r_count;
`else
  assign match_count = '0;
`endif

endmodule

// File: tb/tb_seq_detector_prog.sv
// -----------------------------------------------------------------------------
// tb_seq_detector_prog
//   Directed bench for seq_detector_prog. Three instances share one stimulus
//   stream: u0 default parameters, u1 with OVERLAP=0, u2 with CNT_W=2.
// -----------------------------------------------------------------------------
module tb_seq_detector_prog;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       seq_in;
  logic       cfg_load;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;

  logic       det0, det1, det2;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;

  int n_chk = 0;
  int n_bad = 0;

  localparam byte ONE = "1";

  always #5 clk = ~clk;

  seq_detector_prog u0 (
    .clk(clk), .rst_n(rst_n), .en(en), .seq_in(seq_in), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .detect(det0), .match_count(cnt0)
  );

  seq_detector_prog #(.OVERLAP(0)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .seq_in(seq_in), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .detect(det1), .match_count(cnt1)
  );

  seq_detector_prog #(.CNT_W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .en(en), .seq_in(seq_in), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .detect(det2), .match_count(cnt2)
  );

  // Expected counter value: the counter only exists when the macro is defined
  function automatic int exp_cnt(input int n);
`ifdef SEQ_DET_COUNT_EN
    return n;
`else
    return 0 * n;
`endif
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_cnt(input string tag, input int e0, input int e1, input int e2);
    check_eq({tag, "_cnt0"}, 32'(cnt0), 32'(exp_cnt(e0)));
    check_eq({tag, "_cnt1"}, 32'(cnt1), 32'(exp_cnt(e1)));
    check_eq({tag, "_cnt2"}, 32'(cnt2), 32'(exp_cnt(e2)));
  endtask

  // Drive one cycle per character; d0 is expected detect for u0/u2, d1 for u1
  task automatic play(input string tag, input string bits, input string ens,
                      input string d0, input string d1);
    for (int i = 0; i < bits.len(); i++) begin
      en     = (ens[i] == ONE);
      seq_in = (bits[i] == ONE);
      @(posedge clk);
      #1;
      check_eq($sformatf("%s_u0_c%0d", tag, i), 32'(det0), 32'(d0[i] == ONE));
      check_eq($sformatf("%s_u1_c%0d", tag, i), 32'(det1), 32'(d1[i] == ONE));
      check_eq($sformatf("%s_u2_c%0d", tag, i), 32'(det2), 32'(d0[i] == ONE));
    end
    en     = 1'b0;
    seq_in = 1'b0;
  endtask

  // cfg_load with a competing sample that must be discarded
  task automatic load(input logic [7:0] p, input logic [3:0] l);
    cfg_pattern = p;
    cfg_len     = l;
    cfg_load    = 1'b1;
    en          = 1'b1;
    seq_in      = 1'b1;
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
    en       = 1'b0;
    seq_in   = 1'b0;
    check_eq("load_det0", 32'(det0), 32'd0);
    check_eq("load_det1", 32'(det1), 32'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    en          = 1'b0;
    seq_in      = 1'b0;
    cfg_load    = 1'b0;
    cfg_pattern = 8'h00;
    cfg_len     = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_det0", 32'(det0), 32'd0);
    check_eq("rst_det1", 32'(det1), 32'd0);
    check_cnt("rst", 0, 0, 0);
    rst_n = 1'b1;

    // Default pattern 0101, L=4, HOLD=2
    play("dflt", "0101000", "1111000", "0000110", "0000110");
    check_cnt("dflt", 1, 1, 1);

    // Overlap versus non-overlap on 0101010
    load(8'h05, 4'd4);
    check_cnt("ld1", 0, 0, 0);
    play("ovl", "010101000", "111111100", "000011110", "000011000");
    check_cnt("ovl", 2, 1, 2);

    // Reprogram to an 8-bit pattern, old pattern must no longer fire
    load(8'hD3, 4'd8);
    check_cnt("ld2", 0, 0, 0);
    play("rep", "110100110101000", "111111111111000",
         "000000001100000", "000000001100000");
    check_cnt("rep", 1, 1, 1);

    // Gaps between bits; seq_in toggles during en=0 and must be ignored
    load(8'h05, 4'd4);
    play("gap", "01110111000", "10101010000", "00000001100", "00000001100");
    check_cnt("gap", 1, 1, 1);

    // len=0: detection disabled on a random stream
    load(8'h05, 4'd0);
    for (int i = 0; i < 200; i++) begin
      en     = ($urandom_range(0, 3) != 0);
      seq_in = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check_eq($sformatf("len0_u0_c%0d", i), 32'(det0), 32'd0);
      check_eq($sformatf("len0_u1_c%0d", i), 32'(det1), 32'd0);
    end
    en = 1'b0;
    check_cnt("len0", 0, 0, 0);

    // cfg_load during hold: detect drops, history cleared
    load(8'h05, 4'd4);
    play("hld", "01010", "11111", "00001", "00001");
    load(8'h05, 4'd4);
    check_cnt("hldclr", 0, 0, 0);
    play("hist", "1000", "1000", "0000", "0000");
    play("post", "0101000", "1111000", "0000110", "0000110");
    check_cnt("post", 1, 1, 1);

    // Reset mid-hold falls asynchronously and restores the default pattern
    load(8'h06, 4'd4);
    play("p0110", "01100", "11110", "00001", "00001");
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_det0", 32'(det0), 32'd0);
    check_eq("arst_det1", 32'(det1), 32'd0);
    check_cnt("arst", 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    play("rdef", "0101000", "1111000", "0000110", "0000110");

    // Five overlapping matches: 2-bit counter saturates at 3
    load(8'h05, 4'd4);
    play("sat", "010101010101000", "111111111111000",
         "000011111111110", "000011001100110");
    check_cnt("sat", 5, 3, 3);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
